// File: rtl/mod_arb_pkg.sv
// mod_arb_pkg -- shared state encoding, default parameters and width helpers
// for the modulo-counter arbiter. Rev 1.0
`default_nettype none

package mod_arb_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_MOD      = 3;
    localparam int DEF_MAX_HOLD = 8;

    function automatic int count_width(input int modulus);
        return $clog2(modulus);
    endfunction

    localparam int DEF_CNT_W = count_width(DEF_MOD);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mod_n_counter.sv
// mod_n_counter -- modulo-MOD up counter with Moore terminal decode (hit)
// and a registered wrap pulse. Rev 1.0
`default_nettype none

module mod_n_counter
    import mod_arb_pkg::*;
#(
    parameter int MOD = DEF_MOD
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inc,
    output logic [count_width(MOD)-1:0] count,
    output logic                       hit,
    output logic                       wrap
);

    localparam int CW = count_width(MOD);
    localparam logic [CW-1:0] LAST = CW'(MOD - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            // wrap shows up alongside the freshly-zeroed count
            wrap <= inc && (count == LAST);
            if (inc) begin
                count <= (count == LAST) ? '0 : count + 1'b1;
            end
        end
    end

    assign hit = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/mod_counter_arbiter.sv
// mod_counter_arbiter -- round-robin arbiter granting one requester at a time
// ownership of a shared modulo counter, with a bounded grant tenure. Rev 1.0
`default_nettype none

module mod_counter_arbiter
    import mod_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int MOD      = DEF_MOD,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          ev,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic                        busy,
    output logic [count_width(MOD)-1:0] count,
    output logic                        hit,
    output logic                        wrap,
    output logic                        timeout
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_t     state;
    logic [OW-1:0]  last_owner;
    logic [HW-1:0]  hold;
    logic [OW-1:0]  winner;
    logic           has_req;
    logic           inc;

    // Walk from farthest to nearest so the requester closest after
    // last_owner is the final (winning) assignment.
    always_comb begin
        winner  = last_owner;
        has_req = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last_owner) + k) % NUM_REQ]) begin
                winner  = OW'((int'(last_owner) + k) % NUM_REQ);
                has_req = 1'b1;
            end
        end
    end

    assign inc = (state == ST_GRANT) && ev[owner] && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            owner      <= '0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
            hold       <= '0;
            last_owner <= OW'(NUM_REQ - 1);
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (has_req) begin
                        state <= ST_GRANT;
                        gnt   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                        owner <= winner;
                        busy  <= 1'b1;
                        hold  <= '0;
                    end
                end
                ST_GRANT: begin
                    hold <= hold + 1'b1;
                    if (!req[owner] || (hold == HW'(MAX_HOLD - 1))) begin
                        state   <= ST_RELEASE;
                        gnt     <= '0;
                        busy    <= 1'b0;
                        // a voluntary drop on the last allowed cycle is not a timeout
                        timeout <= req[owner];
                    end
                end
                ST_RELEASE: begin
                    last_owner <= owner;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mod_n_counter #(
        .MOD (MOD)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .count (count),
        .hit   (hit),
        .wrap  (wrap)
    );

endmodule

`default_nettype wire

// File: tb/tb_mod_counter_arbiter.sv
// tb_mod_counter_arbiter -- directed-vector bench for mod_counter_arbiter
// with default parameters (4 requesters, MOD 3, MAX_HOLD 8). Rev 1.0
`default_nettype none

module tb_mod_counter_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] ev;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic [1:0] count;
    logic       hit;
    logic       wrap;
    logic       timeout;

    int vectors     = 0;
    int miscompares = 0;

    mod_counter_arbiter #(
        .NUM_REQ  (4),
        .MOD      (3),
        .MAX_HOLD (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ev      (ev),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .count   (count),
        .hit     (hit),
        .wrap    (wrap),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // advance one cycle and sample 1 time unit after the edge
    task automatic tick;
        @(posedge clk);
        #1;
        vectors++;
        if (!$onehot0(gnt)) begin
            miscompares++;
            $display("FAIL gnt_onehot: gnt=%b, expected at most one bit set", gnt);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 4'b0000; ev = 4'b0000;
        tick; tick;
        vectors++;
        if ({gnt, owner, busy, count, hit, wrap, timeout} !== 12'b0) begin
            miscompares++;
            $display("FAIL reset_state: gnt=%b owner=%0d busy=%b count=%0d hit=%b wrap=%b timeout=%b, expected all zero",
                     gnt, owner, busy, count, hit, wrap, timeout);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_count;
        logic [1:0] exp_cnt [3] = '{2'd1, 2'd2, 2'd0};
        logic       exp_hit [3] = '{1'b0, 1'b1, 1'b0};
        logic       exp_wrp [3] = '{1'b0, 1'b0, 1'b1};
        req = 4'b0001;
        tick;
        vectors++;
        if (gnt !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_grant: gnt=%b owner=%0d busy=%b, expected 0001/0/1", gnt, owner, busy);
        end
        ev = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick;
            vectors++;
            if (count !== exp_cnt[i] || hit !== exp_hit[i] || wrap !== exp_wrp[i]) begin
                miscompares++;
                $display("FAIL single_count[%0d]: count=%0d hit=%b wrap=%b, expected %0d/%b/%b",
                         i, count, hit, wrap, exp_cnt[i], exp_hit[i], exp_wrp[i]);
            end
        end
        ev = 4'b0000;
        tick;
        vectors++;
        if (wrap !== 1'b0 || count !== 2'd0) begin
            miscompares++;
            $display("FAIL wrap_single_pulse: wrap=%b count=%0d, expected 0/0", wrap, count);
        end
        req = 4'b0000;
        tick;
        vectors++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL release_on_drop: gnt=%b busy=%b timeout=%b, expected 0000/0/0", gnt, busy, timeout);
        end
        tick;
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] exp_o [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        int bad;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick;
            vectors++;
            if (gnt !== exp_g[g] || owner !== exp_o[g]) begin
                miscompares++;
                $display("FAIL rr_grant[%0d]: gnt=%b owner=%0d, expected %b/%0d", g, gnt, owner, exp_g[g], exp_o[g]);
            end
            bad = 0;
            for (int c = 0; c < 7; c++) begin
                tick;
                if (gnt !== exp_g[g]) bad++;
            end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL rr_tenure[%0d]: %0d of 7 cycles lost grant, expected 0", g, bad);
            end
            tick;
            vectors++;
            if (gnt !== 4'b0000 || timeout !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_timeout[%0d]: gnt=%b timeout=%b, expected 0000/1", g, gnt, timeout);
            end
            if (g == 4) req = 4'b0000;
            tick;
            vectors++;
            if (gnt !== 4'b0000 || timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_gap[%0d]: gnt=%b timeout=%b, expected 0000/0", g, gnt, timeout);
            end
        end
    endtask

    task automatic test_ignore_nonowner;
        logic [1:0] exp_cnt [3] = '{2'd1, 2'd2, 2'd0};
        req = 4'b0010;
        tick;
        vectors++;
        if (gnt !== 4'b0010 || owner !== 2'd1 || count !== 2'd0) begin
            miscompares++;
            $display("FAIL owner1_grant: gnt=%b owner=%0d count=%0d, expected 0010/1/0", gnt, owner, count);
        end
        ev = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            tick;
            vectors++;
            if (count !== exp_cnt[i]) begin
                miscompares++;
                $display("FAIL owner1_count[%0d]: count=%0d, expected %0d", i, count, exp_cnt[i]);
            end
        end
        ev = 4'b1100;
        tick;
        vectors++;
        if (count !== 2'd0) begin
            miscompares++;
            $display("FAIL nonowner_ignored: count=%0d, expected 0", count);
        end
        ev = 4'b0000; req = 4'b0000;
        tick; tick;
    endtask

    task automatic test_fall_together;
        req = 4'b0001;
        tick;
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL ft_grant: gnt=%b, expected 0001", gnt);
        end
        ev = 4'b0001;
        tick;
        vectors++;
        if (count !== 2'd1) begin
            miscompares++;
            $display("FAIL ft_count1: count=%0d, expected 1", count);
        end
        req = 4'b0000;
        tick;
        vectors++;
        if (count !== 2'd2 || hit !== 1'b1 || gnt !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ft_last_event: count=%0d hit=%b gnt=%b busy=%b, expected 2/1/0000/0", count, hit, gnt, busy);
        end
        ev = 4'b0000;
        tick;
        req = 4'b0100;
        tick;
        vectors++;
        if (gnt !== 4'b0100 || owner !== 2'd2 || count !== 2'd2 || hit !== 1'b1) begin
            miscompares++;
            $display("FAIL ft_next_owner: gnt=%b owner=%0d count=%0d hit=%b, expected 0100/2/2/1", gnt, owner, count, hit);
        end
        req = 4'b0000;
        tick; tick;
    endtask

    task automatic test_reset_in_grant;
        req = 4'b1000;
        tick;
        vectors++;
        if (gnt !== 4'b1000 || count !== 2'd2) begin
            miscompares++;
            $display("FAIL rg_grant: gnt=%b count=%0d, expected 1000/2", gnt, count);
        end
        rst = 1'b1; ev = 4'b1000;
        tick;
        vectors++;
        if (gnt !== 4'b0000 || count !== 2'd0 || hit !== 1'b0 || busy !== 1'b0 || wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL rg_reset: gnt=%b count=%0d hit=%b busy=%b wrap=%b, expected 0000/0/0/0/0",
                     gnt, count, hit, busy, wrap);
        end
        rst = 1'b0; ev = 4'b0000; req = 4'b1111;
        tick;
        vectors++;
        if (gnt !== 4'b0001 || owner !== 2'd0) begin
            miscompares++;
            $display("FAIL rg_first_grant: gnt=%b owner=%0d, expected 0001/0", gnt, owner);
        end
        req = 4'b0000;
        tick; tick;
    endtask

    task automatic test_back_to_back;
        req = 4'b0010;
        tick;
        vectors++;
        if (gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL b2b_first: gnt=%b, expected 0010", gnt);
        end
        for (int c = 0; c < 7; c++) tick;
        tick;
        vectors++;
        if (gnt !== 4'b0000 || timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_timeout: gnt=%b timeout=%b, expected 0000/1", gnt, timeout);
        end
        tick;
        tick;
        vectors++;
        if (gnt !== 4'b0010 || owner !== 2'd1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_regrant: gnt=%b owner=%0d busy=%b, expected 0010/1/1", gnt, owner, busy);
        end
        req = 4'b0000;
        tick; tick;
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; ev = 4'b0000;
        test_reset;
        test_single_count;
        test_round_robin;
        test_ignore_nonowner;
        test_fall_together;
        test_reset_in_grant;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
